// File: rtl/arb_types.sv
// Shared types for the physical-memory arbiter: FSM states, transaction op and channel limit.
package arb_types;

  localparam int unsigned ARB_MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: round-robin from ptr_i+1 with wrap, or lowest index first.
module rr_picker #(
  parameter int unsigned NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  input  logic                      rr_mode_i,
  output logic                      valid_o,
  output logic [$clog2(NUM_CH)-1:0] idx_o
);

  localparam int unsigned IdW = $clog2(NUM_CH);

  int unsigned cand;

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    cand    = 0;
    // Scan from farthest to nearest candidate so the nearest hit is the last assignment.
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = rr_mode_i ? ((int'(ptr_i) + unsigned'(k)) % NUM_CH) : (unsigned'(k) - 1);
      if (req_i[cand[IdW-1:0]]) begin
        idx_o = cand[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// N-channel arbiter in front of a single pmem port; one registered transaction at a time.
module pmem_arbiter
  import arb_types::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned RR_MODE    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              ch_read,
  input  logic [NUM_CH-1:0]              ch_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_address,
  input  logic [NUM_CH*LINE_WIDTH-1:0]   ch_wdata,
  output logic [LINE_WIDTH-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]              ch_resp,
  output logic [$clog2(NUM_CH)-1:0]      grant_id,
  output logic                           busy,
  output logic [ADDR_WIDTH-1:0]          pmem_address,
  output logic [LINE_WIDTH-1:0]          pmem_wdata,
  output logic                           pmem_read,
  output logic                           pmem_write,
  input  logic [LINE_WIDTH-1:0]          pmem_rdata,
  input  logic                           pmem_resp
);

  localparam int unsigned IdW = $clog2(NUM_CH);

  arb_state_t            state_q;
  arb_op_t               op_q;
  logic [IdW-1:0]        grant_q;
  logic [IdW-1:0]        ptr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic [NUM_CH-1:0]     resp_q;
  logic                  busy_q;

  logic [NUM_CH-1:0]     req;
  logic                  win_valid;
  logic [IdW-1:0]        win_idx;

  assign req = ch_read | ch_write;

  rr_picker #(
    .NUM_CH(NUM_CH)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .rr_mode_i(RR_MODE != 0),
    .valid_o  (win_valid),
    .idx_o    (win_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      grant_q <= '0;
      ptr_q   <= IdW'(NUM_CH - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            grant_q <= win_idx;
            addr_q  <= ch_address[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= ch_wdata[win_idx*LINE_WIDTH +: LINE_WIDTH];
            op_q    <= ch_write[win_idx] ? OP_WRITE : OP_READ;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            rdata_q <= pmem_rdata;
            resp_q  <= NUM_CH'(1) << grant_q;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          resp_q <= '0;
          if (RR_MODE != 0) begin
            ptr_q <= grant_q;
          end
          state_q <= IDLE;
        end
        default: begin
          resp_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Strobes derive only from registers so reset drops them without waiting for a clock.
  assign pmem_read    = busy_q & (op_q == OP_READ);
  assign pmem_write   = busy_q & (op_q == OP_WRITE);
  assign busy         = busy_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign ch_rdata     = rdata_q;
  assign ch_resp      = resp_q;
  assign grant_id     = grant_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus randomized traffic against a round-robin model.
module tb_pmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 2 channels, round-robin.
  logic [1:0]   ch_read_a = '0, ch_write_a = '0;
  logic [31:0]  ch_address_a = '0;
  logic [255:0] ch_wdata_a = '0;
  logic [127:0] ch_rdata_a, pmem_wdata_a, pmem_rdata_a = '0;
  logic [1:0]   ch_resp_a;
  logic         grant_id_a, busy_a, pmem_read_a, pmem_write_a, pmem_resp_a = 1'b0;
  logic [15:0]  pmem_address_a;

  // Instance B: 3 channels, fixed priority.
  logic [2:0]   ch_read_b = '0, ch_write_b = '0;
  logic [47:0]  ch_address_b = '0;
  logic [383:0] ch_wdata_b = '0;
  logic [127:0] ch_rdata_b, pmem_wdata_b, pmem_rdata_b = '0;
  logic [2:0]   ch_resp_b;
  logic [1:0]   grant_id_b;
  logic         busy_b, pmem_read_b, pmem_write_b, pmem_resp_b = 1'b0;
  logic [15:0]  pmem_address_b;

  pmem_arbiter #(.NUM_CH(2), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(1)) dut (
    .clk(clk), .reset(reset), .ch_read(ch_read_a), .ch_write(ch_write_a),
    .ch_address(ch_address_a), .ch_wdata(ch_wdata_a), .ch_rdata(ch_rdata_a),
    .ch_resp(ch_resp_a), .grant_id(grant_id_a), .busy(busy_a),
    .pmem_address(pmem_address_a), .pmem_wdata(pmem_wdata_a), .pmem_read(pmem_read_a),
    .pmem_write(pmem_write_a), .pmem_rdata(pmem_rdata_a), .pmem_resp(pmem_resp_a)
  );

  pmem_arbiter #(.NUM_CH(3), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .ch_read(ch_read_b), .ch_write(ch_write_b),
    .ch_address(ch_address_b), .ch_wdata(ch_wdata_b), .ch_rdata(ch_rdata_b),
    .ch_resp(ch_resp_b), .grant_id(grant_id_b), .busy(busy_b),
    .pmem_address(pmem_address_b), .pmem_wdata(pmem_wdata_b), .pmem_read(pmem_read_b),
    .pmem_write(pmem_write_b), .pmem_rdata(pmem_rdata_b), .pmem_resp(pmem_resp_b)
  );

  int n_pass = 0;
  int n_total = 0;

  // Observations from the last served transaction.
  int           s_lat, s_gid;
  logic         s_rd, s_wr;
  logic [15:0]  s_addr;
  logic [127:0] s_wd, s_rdata;
  logic [2:0]   s_resp;

  // Pmem-side responder: waits for a strobe, answers after wait_c cycles, captures the result.
  task automatic serve(input int which, input int wait_c, input logic [127:0] rd);
    s_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (which == 0 ? (pmem_read_a | pmem_write_a) : (pmem_read_b | pmem_write_b)) begin
        s_lat = i;
        break;
      end
    end
    s_rd   = (which == 0) ? pmem_read_a : pmem_read_b;
    s_wr   = (which == 0) ? pmem_write_a : pmem_write_b;
    s_addr = (which == 0) ? pmem_address_a : pmem_address_b;
    s_wd   = (which == 0) ? pmem_wdata_a : pmem_wdata_b;
    s_gid  = (which == 0) ? int'(grant_id_a) : int'(grant_id_b);
    s_resp  = '0;
    s_rdata = '0;
    if (s_lat > 0) begin
      repeat (wait_c) @(negedge clk);
      if (which == 0) begin
        pmem_resp_a = 1'b1; pmem_rdata_a = rd;
      end else begin
        pmem_resp_b = 1'b1; pmem_rdata_b = rd;
      end
      @(negedge clk);
      pmem_resp_a = 1'b0;
      pmem_resp_b = 1'b0;
      s_resp  = (which == 0) ? {1'b0, ch_resp_a} : ch_resp_b;
      s_rdata = (which == 0) ? ch_rdata_a : ch_rdata_b;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if ({pmem_read_a, pmem_write_a, busy_a, ch_resp_a, grant_id_a, pmem_address_a,
         pmem_wdata_a, ch_rdata_a} !== '0)
      $display("FAIL reset_a: outputs not all zero (addr=%h resp=%b)", pmem_address_a, ch_resp_a);
    else n_pass++;
    n_total++;
    if ({pmem_read_b, pmem_write_b, busy_b, ch_resp_b, grant_id_b, pmem_address_b} !== '0)
      $display("FAIL reset_b: outputs not all zero (addr=%h resp=%b)", pmem_address_b, ch_resp_b);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    // Stray pmem_resp while idle must not produce a channel response.
    pmem_resp_a = 1'b1;
    @(negedge clk);
    pmem_resp_a = 1'b0;
    n_total++;
    if ({ch_resp_a, busy_a} !== 3'b000)
      $display("FAIL idle_resp: got resp=%b busy=%b want 00/0", ch_resp_a, busy_a);
    else n_pass++;
  endtask

  task automatic test_single_read();
    ch_address_a[15:0] = 16'h1230;
    ch_read_a[0] = 1'b1;
    serve(0, 4, {16{8'hA5}});
    n_total++;
    if (s_lat !== 1) $display("FAIL single_lat: got %0d want 1", s_lat); else n_pass++;
    n_total++;
    if ({s_rd, s_wr} !== 2'b10) $display("FAIL single_op: got %b want 10", {s_rd, s_wr});
    else n_pass++;
    n_total++;
    if (s_addr !== 16'h1230) $display("FAIL single_addr: got %h want 1230", s_addr); else n_pass++;
    n_total++;
    if (s_resp !== 3'b001) $display("FAIL single_resp: got %b want 001", s_resp); else n_pass++;
    n_total++;
    if (s_rdata !== {16{8'hA5}}) $display("FAIL single_rdata: got %h want a5..a5", s_rdata);
    else n_pass++;
    ch_read_a[0] = 1'b0;
    @(negedge clk);
    n_total++;
    if ({ch_resp_a, pmem_read_a, busy_a} !== 4'b0000)
      $display("FAIL single_pulse: got resp=%b rd=%b busy=%b want 0", ch_resp_a, pmem_read_a,
               busy_a);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [127:0] w1;
    w1 = {$urandom, $urandom, $urandom, $urandom};
    reset = 1'b1;
    ch_read_a = 2'b01;
    ch_write_a = 2'b10;
    ch_address_a = {16'h0200, 16'h0100};
    ch_wdata_a[255:128] = w1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    serve(0, 0, 128'h1111);
    n_total++;
    if (s_gid !== 0 || s_addr !== 16'h0100 || s_resp !== 3'b001)
      $display("FAIL sim_first: got gid=%0d addr=%h resp=%b want 0/0100/001", s_gid, s_addr,
               s_resp);
    else n_pass++;
    ch_read_a[0] = 1'b0;
    serve(0, 1, 128'h2222);
    n_total++;
    if (s_gid !== 1 || {s_rd, s_wr} !== 2'b01 || s_wd !== w1 || s_resp !== 3'b010)
      $display("FAIL sim_second: got gid=%0d op=%b wd=%h resp=%b want 1/01/%h/010", s_gid,
               {s_rd, s_wr}, s_wd, s_resp, w1);
    else n_pass++;
    ch_write_a[1] = 1'b0;
    @(negedge clk);
    ch_read_a = 2'b01;
    ch_write_a = 2'b10;
    serve(0, 0, 128'h3333);
    n_total++;
    if (s_gid !== 0) $display("FAIL sim_retie: got gid=%0d want 0", s_gid); else n_pass++;
    ch_read_a[0] = 1'b0;
    serve(0, 0, 128'h4444);
    n_total++;
    if (s_gid !== 1 || s_resp !== 3'b010)
      $display("FAIL sim_loser: got gid=%0d resp=%b want 1/010", s_gid, s_resp);
    else n_pass++;
    ch_write_a[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_change();
    ch_address_a[15:0] = 16'h0040;
    ch_read_a[0] = 1'b1;
    @(negedge clk);
    ch_address_a[15:0] = 16'h0080;
    @(negedge clk);
    n_total++;
    if (pmem_address_a !== 16'h0040)
      $display("FAIL mid_addr_busy: got %h want 0040", pmem_address_a);
    else n_pass++;
    serve(0, 2, 128'h5555);
    n_total++;
    if (s_addr !== 16'h0040 || s_resp !== 3'b001)
      $display("FAIL mid_addr_end: got addr=%h resp=%b want 0040/001", s_addr, s_resp);
    else n_pass++;
    ch_read_a[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    ch_address_a[15:0] = 16'h0300;
    ch_read_a[0] = 1'b1;
    @(negedge clk);
    n_total++;
    if (pmem_read_a !== 1'b1) $display("FAIL rb_pre: got rd=%b want 1", pmem_read_a);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if ({pmem_read_a, busy_a, ch_resp_a} !== 4'b0000)
      $display("FAIL rb_async: got rd=%b busy=%b resp=%b want 0", pmem_read_a, busy_a, ch_resp_a);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    serve(0, 1, 128'h6666);
    n_total++;
    if (s_lat !== 1 || s_gid !== 0 || s_addr !== 16'h0300 || s_resp !== 3'b001)
      $display("FAIL rb_regrant: got lat=%0d gid=%0d addr=%h resp=%b want 1/0/0300/001", s_lat,
               s_gid, s_addr, s_resp);
    else n_pass++;
    ch_read_a[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rw_both();
    logic [127:0] w2;
    w2 = {$urandom, $urandom, $urandom, $urandom};
    ch_address_a[31:16] = 16'h0500;
    ch_wdata_a[255:128] = w2;
    ch_read_a[1] = 1'b1;
    ch_write_a[1] = 1'b1;
    serve(0, 0, 128'h7777);
    n_total++;
    if ({s_rd, s_wr} !== 2'b01 || s_gid !== 1 || s_wd !== w2 || s_resp !== 3'b010)
      $display("FAIL rw_both: got op=%b gid=%0d wd=%h resp=%b want 01/1/%h/010", {s_rd, s_wr},
               s_gid, s_wd, s_resp, w2);
    else n_pass++;
    ch_read_a[1] = 1'b0;
    ch_write_a[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    ch_address_b = {16'h1200, 16'h1100, 16'h1000};
    ch_read_b = 3'b111;
    for (int r = 0; r < 3; r++) begin
      serve(1, r, 128'h8888 + 128'(r));
      n_total++;
      if (s_gid !== 0 || s_addr !== 16'h1000 || s_resp !== 3'b001)
        $display("FAIL fp_round%0d: got gid=%0d addr=%h resp=%b want 0/1000/001", r, s_gid,
                 s_addr, s_resp);
      else n_pass++;
    end
    ch_read_b[0] = 1'b0;
    serve(1, 0, 128'h9999);
    n_total++;
    if (s_gid !== 1 || s_addr !== 16'h1100 || s_resp !== 3'b010)
      $display("FAIL fp_ch1: got gid=%0d addr=%h resp=%b want 1/1100/010", s_gid, s_addr, s_resp);
    else n_pass++;
    ch_read_b[1] = 1'b0;
    serve(1, 0, 128'hAAAA);
    n_total++;
    if (s_gid !== 2 || s_resp !== 3'b100 || s_rdata !== 128'hAAAA)
      $display("FAIL fp_ch2: got gid=%0d resp=%b rdata=%h want 2/100/aaaa", s_gid, s_resp,
               s_rdata);
    else n_pass++;
    ch_read_b[2] = 1'b0;
    @(negedge clk);
  endtask

  // Model: each channel holds at most one request; the winner is the first pending channel
  // strictly after the last one served, wrapping around.
  task automatic test_random();
    bit           pend[2];
    bit           mwr[2];
    logic [15:0]  maddr[2];
    logic [127:0] mwd[2];
    logic [127:0] rd;
    int           last, w, op;
    do_reset();
    last = 1;
    pend[0] = 0;
    pend[1] = 0;
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pend[c] && $urandom_range(1, 0) == 1) begin
          op = $urandom_range(2, 0);
          pend[c] = 1;
          mwr[c] = (op != 0);
          maddr[c] = 16'($urandom);
          mwd[c] = {$urandom, $urandom, $urandom, $urandom};
          ch_read_a[c] = (op != 1);
          ch_write_a[c] = (op != 0);
          ch_address_a[c*16 +: 16] = maddr[c];
          ch_wdata_a[c*128 +: 128] = mwd[c];
        end
      end
      if (!pend[0] && !pend[1]) begin
        w = $urandom_range(1, 0);
        pend[w] = 1;
        mwr[w] = 0;
        maddr[w] = 16'($urandom);
        ch_read_a[w] = 1'b1;
        ch_address_a[w*16 +: 16] = maddr[w];
      end
      w = pend[(last + 1) % 2] ? (last + 1) % 2 : last;
      rd = {$urandom, $urandom, $urandom, $urandom};
      serve(0, $urandom_range(3, 0), rd);
      n_total++;
      if (s_lat < 1 || s_gid !== w)
        $display("FAIL rnd%0d_grant: got lat=%0d gid=%0d want gid=%0d", r, s_lat, s_gid, w);
      else n_pass++;
      n_total++;
      if ({s_rd, s_wr} !== {!mwr[w], mwr[w]} || s_addr !== maddr[w])
        $display("FAIL rnd%0d_req: got op=%b addr=%h want op=%b addr=%h", r, {s_rd, s_wr}, s_addr,
                 {!mwr[w], mwr[w]}, maddr[w]);
      else n_pass++;
      if (mwr[w]) begin
        n_total++;
        if (s_wd !== mwd[w]) $display("FAIL rnd%0d_wdata: got %h want %h", r, s_wd, mwd[w]);
        else n_pass++;
      end
      n_total++;
      if (s_resp !== 3'(1 << w) || s_rdata !== rd)
        $display("FAIL rnd%0d_resp: got resp=%b rdata=%h want %b/%h", r, s_resp, s_rdata,
                 3'(1 << w), rd);
      else n_pass++;
      ch_read_a[w] = 1'b0;
      ch_write_a[w] = 1'b0;
      pend[w] = 0;
      last = w;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_mid_change();
    test_reset_busy();
    test_rw_both();
    test_fixed_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
